// File: rtl/uart_rx_multi_if.sv
// Valid/ready word stream leaving the UART receiver: head-of-FIFO data plus
// the error tags captured with that word.
interface uart_rx_multi_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_parity_err;
  logic                 out_frame_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data,
    output out_parity_err,
    output out_frame_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_parity_err,
    input  out_frame_err,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_multi.sv
// Configurable UART receiver: 2-flop input synchroniser, 16x oversampling
// with 3-sample majority vote, parity/stop checking with per-word error tags,
// and a power-of-two receive FIFO with sticky overrun.
module uart_rx_multi #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in,
  uart_rx_multi_if.master               bus,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int OS_CYCLES = CLK_FREQ_HZ / (BAUD_RATE * 16);
  localparam int OS_W      = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int PW        = AW + 1;
  localparam int WORD_W    = DATA_BITS + 2;
  localparam int BC_W      = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_multi: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_multi: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_multi: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_multi: FIFO_DEPTH must be a power of two >= 2");
  end
  if (OS_CYCLES < 1) begin : g_bad_rate
    $error("uart_rx_multi: CLK_FREQ_HZ too low for 16x oversampling of BAUD_RATE");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic rx_p0, rx_p1, rx_s;

  // Input synchroniser: the line is asynchronous, idle-high after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= in;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  logic start_det;
  assign start_det = (state == S_IDLE) && !rx_s;

  // Oversample tick generation and bit-phase tracking.
  logic [OS_W-1:0] os_cnt;
  logic            tick;
  logic [3:0]      ph, ph_nxt;
  logic            dec, eob;

  assign tick   = (os_cnt == OS_W'(OS_CYCLES - 1));
  assign ph_nxt = ph + 4'd1;
  assign dec    = tick && (ph_nxt == 4'd9);
  assign eob    = tick && (ph_nxt == 4'd15);

  // Divider realigned to the start edge so the sample ticks sit mid-bit.
  always_ff @(posedge clk) begin
    if (!rst_n || start_det) begin
      os_cnt <= '0;
    end else if (tick) begin
      os_cnt <= '0;
    end else begin
      os_cnt <= os_cnt + 1'b1;
    end
  end

  // Tick index within the current bit; wraps every 16 ticks.
  always_ff @(posedge clk) begin
    if (!rst_n || start_det) begin
      ph <= '0;
    end else if (tick) begin
      ph <= ph_nxt;
    end
  end

  logic s7, s8, vote;

  // Hold the first two mid-bit samples until the deciding third tick.
  always_ff @(posedge clk) begin
    if (tick && ph_nxt == 4'd7) s7 <= rx_s;
    if (tick && ph_nxt == 4'd8) s8 <= rx_s;
  end

  assign vote = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_r, ferr_r;
  logic                 shift_en, par_chk, stop_chk, push, cnt_clr, cnt_inc;
  logic                 par_ok;
  logic [WORD_W-1:0]    push_word;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing: next state plus datapath strobes for each bit decision.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    push      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (dec && vote) begin
          state_nxt = S_IDLE;
        end else if (eob) begin
          state_nxt = S_DATA;
          cnt_clr   = 1'b1;
        end
      end
      S_DATA: begin
        if (dec) shift_en = 1'b1;
        if (eob) begin
          if (bit_cnt == BC_W'(DATA_BITS - 1)) begin
            cnt_clr   = 1'b1;
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (dec) par_chk = 1'b1;
        if (eob) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (dec) begin
          stop_chk = 1'b1;
          if (bit_cnt == BC_W'(STOP_BITS - 1)) begin
            push      = 1'b1;
            state_nxt = (ferr_r || !vote) ? S_BREAK : S_IDLE;
          end
        end
        if (eob) cnt_inc = 1'b1;
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit counter shared by the data and stop phases.
  always_ff @(posedge clk) begin
    if (!rst_n || start_det || cnt_clr) begin
      bit_cnt <= '0;
    end else if (cnt_inc) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // LSB-first shift: each voted bit enters at the top and moves down.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

  assign par_ok = (PARITY == 1) ? (^{shreg, vote}) : ~(^{shreg, vote});

  // Per-word error tags, cleared at each new start bit.
  always_ff @(posedge clk) begin
    if (start_det) begin
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      if (par_chk)  perr_r <= ~par_ok;
      if (stop_chk) ferr_r <= ferr_r | ~vote;
    end
  end

  assign push_word = {ferr_r | ~vote, perr_r, shreg};

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, level;
  logic              full, empty, pop, wr_en;
  logic [WORD_W-1:0] head;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == PW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = !empty && bus.out_ready;
  assign wr_en = push && (!full || pop);

  // FIFO storage; a push into a full FIFO is accepted only alongside a pop.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // FIFO pointers, wrapping naturally with one extra bit for full/empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overrun; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (push && full && !pop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign head               = mem[rd_ptr[AW-1:0]];
  assign fifo_level         = level;
  assign bus.out_valid      = !empty;
  assign bus.out_data       = empty ? '0   : head[DATA_BITS-1:0];
  assign bus.out_parity_err = empty ? 1'b0 : head[DATA_BITS];
  assign bus.out_frame_err  = empty ? 1'b0 : head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_multi.sv
// Scoreboard bench for uart_rx_multi: three receivers (8N1, 7E1, 8N2) share a
// clock; stimulus queues the word each frame should yield and a monitor
// checks every word the receivers hand over.
module tb_uart_rx_multi;

  // 700 kHz / (10 kBd * 16) truncates to 4 clocks per tick: 64 clocks per bit.
  localparam int CLK_HZ   = 700_000;
  localparam int BAUD     = 10_000;
  localparam int BP       = 64;
  localparam int GAP      = 100;
  localparam int DEPTH    = 16;

  int nb  [3] = '{8, 7, 8};
  int par [3] = '{0, 2, 0};
  int ns  [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [2:0] ovr_clr = 3'b000;
  logic [2:0] ovr;
  logic [4:0] lvl [3];
  logic [2:0] vld, pe, fe;
  logic [8:0] dat [3];

  int rdy_mode [3] = '{1, 1, 1};
  logic [2:0] exp_ovr = 3'b000;

  int n_cmp = 0;
  int n_fail = 0;

  logic [10:0] q0[$], q1[$], q2[$];

  uart_rx_multi_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_multi_if #(.DATA_BITS(7)) bus1 ();
  uart_rx_multi_if #(.DATA_BITS(8)) bus2 ();

  uart_rx_multi #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(line[0]), .bus(bus0),
    .overrun(ovr[0]), .overrun_clr(ovr_clr[0]), .fifo_level(lvl[0]));

  uart_rx_multi #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(line[1]), .bus(bus1),
    .overrun(ovr[1]), .overrun_clr(ovr_clr[1]), .fifo_level(lvl[1]));

  uart_rx_multi #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(line[2]), .bus(bus2),
    .overrun(ovr[2]), .overrun_clr(ovr_clr[2]), .fifo_level(lvl[2]));

  assign bus0.out_ready = rdy[0];
  assign bus1.out_ready = rdy[1];
  assign bus2.out_ready = rdy[2];
  assign vld = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign pe  = {bus2.out_parity_err, bus1.out_parity_err, bus0.out_parity_err};
  assign fe  = {bus2.out_frame_err, bus1.out_frame_err, bus0.out_frame_err};
  assign dat[0] = {1'b0, bus0.out_data};
  assign dat[1] = {2'b00, bus1.out_data};
  assign dat[2] = {1'b0, bus2.out_data};

  always #5 clk = ~clk;

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic exp_push(input int k, input logic [10:0] w);
    case (k)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic exp_pop(input int k, output logic [10:0] w);
    case (k)
      0:       w = q0.pop_front();
      1:       w = q1.pop_front();
      default: w = q2.pop_front();
    endcase
  endtask

  // Reference: the word a receiver of configuration k should store for the
  // bits actually placed on the line.
  function automatic logic [10:0] model(input int k, input logic [8:0] d,
                                        input logic pbit, input logic [1:0] stops);
    logic [8:0] dm;
    int         ones;
    logic       perr, ferr;
    dm   = d & ((9'h1 << nb[k]) - 9'h1);
    ones = $countones(dm) + int'(pbit);
    if (par[k] == 0)      perr = 1'b0;
    else if (par[k] == 1) perr = (ones % 2) == 0;
    else                  perr = (ones % 2) == 1;
    ferr = (stops[0] == 1'b0) || (ns[k] == 2 && stops[1] == 1'b0);
    return {ferr, perr, dm};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int k, input logic v, input logic glitch);
    line[k] = v;
    if (glitch) begin
      cyc(31);
      line[k] = ~v;
      cyc(2);
      line[k] = v;
      cyc(BP - 33);
    end else begin
      cyc(BP);
    end
  endtask

  task automatic send(input int k, input logic [8:0] d, input logic pinv,
                      input logic [1:0] stops, input int glitch_bit, input int low_after);
    logic [8:0]  dm;
    logic        pbit;
    logic [10:0] w;
    dm   = d & ((9'h1 << nb[k]) - 9'h1);
    pbit = ((par[k] == 1) ? ~(^dm) : (^dm)) ^ pinv;
    drive_bit(k, 1'b0, 1'b0);
    for (int i = 0; i < nb[k]; i++) drive_bit(k, dm[i], i == glitch_bit);
    if (par[k] != 0) drive_bit(k, pbit, 1'b0);
    w = model(k, dm, pbit, stops);
    if (rdy_mode[k] == 0 && exp_size(k) >= DEPTH) exp_ovr[k] = 1'b1;
    else exp_push(k, w);
    for (int i = 0; i < ns[k]; i++) drive_bit(k, stops[i], 1'b0);
    if (low_after > 0) begin
      line[k] = 1'b0;
      cyc(low_after);
    end
    line[k] = 1'b1;
    cyc(GAP);
  endtask

  task automatic wait_drain(input int k);
    int t;
    t = 0;
    while (exp_size(k) != 0 && t < 4000) begin
      cyc(1);
      t++;
    end
    if (exp_size(k) != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout dut%0d: got %0d words outstanding, expected 0", k, exp_size(k));
    end
  endtask

  task automatic send_random(input int k, input int count);
    logic [1:0] st;
    int         g;
    for (int i = 0; i < count; i++) begin
      st = 2'b11;
      if ($urandom_range(0, 4) == 0) st[0] = 1'b0;
      if ($urandom_range(0, 4) == 0) st[1] = 1'b0;
      g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb[k] - 1)) : -1;
      send(k, 9'($urandom), ($urandom_range(0, 3) == 0), st, g, 0);
    end
  endtask

  // Consumer side: per-receiver ready policy, changed just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        rdy[k] = (rdy_mode[k] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[k] == 1);
    end
  end

  logic [10:0] mon_w;
  logic [10:0] hold [3];
  logic [2:0]  hold_v = 3'b000;

  // Monitor: every accepted word must match the head of its expectation queue,
  // and a stalled head must not change.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (vld[k] && rdy[k]) begin
          if (exp_size(k) == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_word dut%0d: got 0x%0h, expected no word", k,
                     {fe[k], pe[k], dat[k]});
          end else begin
            exp_pop(k, mon_w);
            chk($sformatf("word_dut%0d", k), int'({fe[k], pe[k], dat[k]}), int'(mon_w));
          end
          hold_v[k] = 1'b0;
        end else if (vld[k]) begin
          if (hold_v[k])
            chk($sformatf("hold_stable_dut%0d", k), int'({fe[k], pe[k], dat[k]}), int'(hold[k]));
          hold[k]   = {fe[k], pe[k], dat[k]};
          hold_v[k] = 1'b1;
        end else begin
          hold_v[k] = 1'b0;
        end
      end
    end else begin
      hold_v = 3'b000;
    end
  end

  initial begin
    rst_n = 1'b0;
    cyc(5);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_valid_dut%0d", k), int'(vld[k]), 0);
      chk($sformatf("reset_level_dut%0d", k), int'(lvl[k]), 0);
      chk($sformatf("reset_overrun_dut%0d", k), int'(ovr[k]), 0);
      chk($sformatf("reset_data_dut%0d", k), int'(dat[k]), 0);
      chk($sformatf("reset_errs_dut%0d", k), int'({fe[k], pe[k]}), 0);
    end
    rst_n = 1'b1;
    cyc(20);

    // 8N1 directed frame
    send(0, 9'h0A5, 1'b0, 2'b11, -1, 0);
    wait_drain(0);
    cyc(2);
    chk("level_after_a5", int'(lvl[0]), 0);

    // start-bit glitch, then a frame with a short pulse inside a data bit
    line[0] = 1'b0;
    cyc(20);
    line[0] = 1'b1;
    cyc(300);
    chk("glitch_level", int'(lvl[0]), 0);
    chk("glitch_valid", int'(vld[0]), 0);
    send(0, 9'h05A, 1'b0, 2'b11, 3, 0);
    send(0, 9'h0C3, 1'b0, 2'b11, 6, 0);
    wait_drain(0);

    rdy_mode[0] = 2;
    send_random(0, 8);
    rdy_mode[0] = 1;
    wait_drain(0);

    // 7E1: wrong then right parity bit for 0x55
    send(1, 9'h055, 1'b1, 2'b11, -1, 0);
    send(1, 9'h055, 1'b0, 2'b11, -1, 0);
    wait_drain(1);
    rdy_mode[1] = 2;
    send_random(1, 8);
    rdy_mode[1] = 1;
    wait_drain(1);

    // 8N2: second stop low, line held low, then a clean frame
    send(2, 9'h03C, 1'b0, 2'b01, -1, 2000);
    send(2, 9'h081, 1'b0, 2'b11, -1, 0);
    wait_drain(2);
    chk("break_level", int'(lvl[2]), 0);
    rdy_mode[2] = 2;
    send_random(2, 8);
    rdy_mode[2] = 1;
    wait_drain(2);

    // reset during data bit 3 of 0xFF
    line[0] = 1'b0;
    cyc(BP);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b0);
    line[0] = 1'b1;
    cyc(20);
    rst_n = 1'b0;
    cyc(4);
    rst_n = 1'b1;
    cyc(1000);
    chk("midreset_valid", int'(vld[0]), 0);
    chk("midreset_level", int'(lvl[0]), 0);
    send(0, 9'h012, 1'b0, 2'b11, -1, 0);
    wait_drain(0);

    // overrun: 17 frames with no consumer
    rdy_mode[0] = 0;
    cyc(2);
    for (int i = 0; i <= 16; i++) send(0, 9'(i), 1'b0, 2'b11, -1, 0);
    cyc(10);
    chk("overrun_level_full", int'(lvl[0]), DEPTH);
    chk("overrun_set", int'(ovr[0]), int'(exp_ovr[0]));
    chk("overrun_valid", int'(vld[0]), 1);
    rdy_mode[0] = 1;
    wait_drain(0);
    cyc(2);
    chk("overrun_drained_level", int'(lvl[0]), 0);
    chk("overrun_sticky", int'(ovr[0]), int'(exp_ovr[0]));
    ovr_clr[0] = 1'b1;
    cyc(1);
    ovr_clr[0] = 1'b0;
    exp_ovr[0] = 1'b0;
    cyc(1);
    chk("overrun_cleared", int'(ovr[0]), 0);

    cyc(50);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("final_overrun_dut%0d", k), int'(ovr[k]), int'(exp_ovr[k]));
      chk($sformatf("final_level_dut%0d", k), int'(lvl[k]), 0);
      chk($sformatf("final_queue_dut%0d", k), exp_size(k), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
